// File: rtl/mesh_term_tx.sv
// mesh_term_tx: terminal transmit queue that formats local packets, filters bad destinations
// and feeds them in order to the mesh router, with drop/sent statistics.
module mesh_term_tx #(
   parameter int         pckg_sz    = 40,
   parameter int         fifo_depth = 4,
   parameter int         ROWS       = 4,
   parameter int         COLUMS     = 4,
   parameter logic [7:0] bdcst      = 8'hFF,
   parameter logic [3:0] id_row     = 4'd0,
   parameter logic [3:0] id_col     = 4'd1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [3:0]         wr_row,
   input  logic [3:0]         wr_col,
   input  logic               wr_bcst,
   input  logic               wr_mode,
   input  logic [pckg_sz-18:0] wr_payload,
   output logic               full,
   output logic [pckg_sz-1:0] data_out_i_in,
   output logic               pndng_i_in,
   input  logic               popin,
   output logic [7:0]         drop_cnt,
   output logic [15:0]        sent_cnt,
   output logic               err_underflow
);
   localparam int aw = $clog2(fifo_depth);
   localparam logic [4:0] row_max = 5'(ROWS + 1);
   localparam logic [4:0] col_max = 5'(COLUMS + 1);
   logic [pckg_sz-1:0] mem [fifo_depth];
   logic [aw-1:0] rd_ptr, wr_ptr;
   logic [aw:0] count;
   logic [7:0] dest;
   logic addr_bad, do_pop, accept, reject;
   always_comb begin
      dest = wr_bcst ? bdcst : {wr_row, wr_col};
      addr_bad = !wr_bcst && ({1'b0, wr_row} > row_max || {1'b0, wr_col} > col_max || dest == {id_row, id_col});
      do_pop = popin && pndng_i_in;
      // a full queue still takes a push when the head leaves on the same edge
      accept = wr_en && !addr_bad && (!full || popin);
      reject = wr_en && !accept;
   end
   // occupancy never exceeds fifo_depth, a power of two, so its top bit is the full flag
   assign full = count[aw];
   assign pndng_i_in = count != '0;
   assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         drop_cnt <= '0;
         sent_cnt <= '0;
         err_underflow <= 1'b0;
         for (int i = 0; i < fifo_depth; i++) mem[i] <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= {8'h00, dest, wr_mode, wr_payload};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            sent_cnt <= sent_cnt + 16'd1;
         end
         count <= (accept && !do_pop) ? count + 1'b1 : (!accept && do_pop) ? count - 1'b1 : count;
         if (reject && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         if (popin && !pndng_i_in) err_underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mesh_term_tx.sv
// tb_mesh_term_tx: scoreboard bench for mesh_term_tx; directed scenarios followed by random
// traffic, with a negedge monitor comparing popped heads and status against a queue model.
module tb_mesh_term_tx;
   localparam int PS = 40;
   localparam int DEPTH = 4;
   localparam int PW = PS - 17;
   logic clk = 0;
   logic reset = 1;
   logic wr_en = 0, wr_bcst = 0, wr_mode = 0, popin = 0;
   logic [3:0] wr_row = 0, wr_col = 0;
   logic [PW-1:0] wr_payload = 0;
   logic full, pndng_i_in, err_underflow;
   logic [PS-1:0] data_out_i_in;
   logic [7:0] drop_cnt;
   logic [15:0] sent_cnt;
   int errors = 0, checks = 0;
   logic [PS-1:0] exp_q[$];
   int exp_drop = 0, exp_sent = 0;
   bit exp_err = 0;

   mesh_term_tx dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_bcst(wr_bcst), .wr_mode(wr_mode), .wr_payload(wr_payload), .full(full),
      .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
      .drop_cnt(drop_cnt), .sent_cnt(sent_cnt), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [PS-1:0] pkt(input bit bc, input logic [3:0] r, input logic [3:0] c,
                                         input bit m, input logic [PW-1:0] p);
      logic [7:0] d;
      d = bc ? 8'hFF : {r, c};
      return {8'h00, d, m, p};
   endfunction

   // monitor: status against the model every cycle, head against the scoreboard on each pop
   always @(negedge clk) begin
      if (reset) begin
         check("full", full, exp_q.size() == DEPTH);
         check("pndng", pndng_i_in, exp_q.size() != 0);
         check("drop_cnt", drop_cnt, 64'(exp_drop));
         check("sent_cnt", sent_cnt, 64'(exp_sent));
         check("err_underflow", err_underflow, exp_err);
         if (exp_q.size() == 0) check("empty_data", data_out_i_in, 0);
         if (popin && pndng_i_in) begin
            if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
            else check("head", data_out_i_in, exp_q.pop_front());
         end
      end
   end

   // called at posedge+1; drives one cycle and updates the model after the edge
   task automatic step(input bit en, input logic [3:0] r, input logic [3:0] c, input bit bc,
                       input bit m, input logic [PW-1:0] p, input bit pop);
      bit ok, popv, acc;
      wr_en = en; wr_row = r; wr_col = c; wr_bcst = bc; wr_mode = m; wr_payload = p; popin = pop;
      ok = bc || (r <= 5 && c <= 5 && !(r == 0 && c == 1));
      popv = pop && exp_q.size() != 0;
      acc = en && ok && (exp_q.size() < DEPTH || popv);
      @(posedge clk); #1;
      if (acc) exp_q.push_back(pkt(bc, r, c, m, p));
      if (en && !acc && exp_drop < 255) exp_drop++;
      if (popv) exp_sent = (exp_sent + 1) % 65536;
      if (pop && !popv) exp_err = 1;
      wr_en = 0; popin = 0;
   endtask

   task automatic pulse_reset();
      reset = 0;
      #1;
      check("rst_pndng", pndng_i_in, 0);
      check("rst_full", full, 0);
      check("rst_data", data_out_i_in, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_sent", sent_cnt, 0);
      check("rst_err", err_underflow, 0);
      exp_q.delete();
      exp_drop = 0; exp_sent = 0; exp_err = 0;
      #2 reset = 1;
   endtask

   initial begin
      logic [PS-1:0] p1, p2;
      #1 reset = 0;
      #1;
      check("init_pndng", pndng_i_in, 0);
      check("init_data", data_out_i_in, 0);
      check("init_full", full, 0);
      @(posedge clk); #1 reset = 1;
      // single push, one-cycle latency and field layout
      step(1, 2, 3, 0, 0, 23'h15A5A5, 0);
      check("fmt_pndng", pndng_i_in, 1);
      check("fmt_data", data_out_i_in, {8'h00, 4'd2, 4'd3, 1'b0, 23'h15A5A5});
      step(0, 0, 0, 0, 0, 0, 1);
      // fill, overflow, drain in order
      @(posedge clk); #1 pulse_reset();
      for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 2, 0, i[0], PW'(100 + i), 0);
      check("fill_full", full, 1);
      check("fill_drop", drop_cnt, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
      check("drain_sent", sent_cnt, 4);
      check("drain_pndng", pndng_i_in, 0);
      // push and pop together while full
      for (int i = 0; i < 4; i++) step(1, 3, 4'(i), 0, 1, PW'(200 + i), 0);
      p2 = pkt(0, 3, 1, 1, PW'(201));
      step(1, 5, 5, 0, 0, PW'(999), 1);
      check("fullpp_full", full, 1);
      check("fullpp_head", data_out_i_in, p2);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
      // underflow is sticky
      pulse_reset();
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      check("uf_err", err_underflow, 1);
      check("uf_pndng", pndng_i_in, 0);
      check("uf_sent", sent_cnt, 0);
      // broadcast overrides address, own id rejected
      step(1, 9, 9, 1, 0, PW'(55), 0);
      check("bc_dest", data_out_i_in[PS-9:PS-16], 8'hFF);
      check("bc_pndng", pndng_i_in, 1);
      step(1, 0, 1, 0, 0, PW'(56), 0);
      check("own_drop", drop_cnt, 1);
      // asynchronous reset with packets queued
      step(1, 1, 1, 0, 0, PW'(1), 0);
      step(1, 1, 2, 0, 0, PW'(2), 0);
      #2 pulse_reset();
      p1 = pkt(0, 2, 2, 1, PW'(77));
      @(posedge clk); #1;
      step(1, 2, 2, 0, 1, PW'(77), 0);
      check("post_rst_data", data_out_i_in, p1);
      check("post_rst_full", full, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("post_rst_pndng", pndng_i_in, 0);
      // drop counter saturation
      for (int i = 0; i < 260; i++) step(1, 15, 0, 0, 0, 0, 0);
      check("drop_sat", drop_cnt, 255);
      // random traffic
      pulse_reset();
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
              $urandom_range(0, 7) == 0, 1'($urandom), PW'($urandom), $urandom_range(0, 1) == 1);
      for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 0, 0, 0, 1);
      check("final_pndng", pndng_i_in, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
